// File: rtl/alert_pkg.sv
// Shared types and constants for the deterministic alert handler ping scheduler.
package alert_pkg;

  parameter int unsigned NAlertsDef = 4;
  parameter int unsigned NEscDef    = 4;
  parameter int unsigned CntDwDef   = 24;
  parameter int unsigned NPingSlots = NAlertsDef + NEscDef;

  typedef enum logic [1:0] {
    PsIdle = 2'd0,
    PsWait = 2'd1,
    PsPing = 2'd2
  } ping_state_e;

  typedef logic [CntDwDef-1:0] ping_cnt_t;

endpackage

// File: rtl/alert_handler_ping_slot_dec.sv
// Slot pointer to one-hot alert/escalation vectors; slots past NAlerts map to senders.
module alert_handler_ping_slot_dec #(
  parameter int unsigned NAlerts = 4,
  parameter int unsigned NEsc    = 4,
  parameter int unsigned PtrW    = 3
) (
  input  logic [PtrW-1:0]    ptr,
  output logic [NAlerts-1:0] alert_oh,
  output logic [NEsc-1:0]    esc_oh
);

  for (genvar i = 0; i < NAlerts; i++) begin : g_alert
    assign alert_oh[i] = (ptr == PtrW'(i));
  end

  for (genvar j = 0; j < NEsc; j++) begin : g_esc
    assign esc_oh[j] = (ptr == PtrW'(NAlerts + j));
  end

endmodule

// File: rtl/alert_handler_ping_sched.sv
// Round-robin liveness ping scheduler: one outstanding ping, programmable gap and timeout.
module alert_handler_ping_sched
  import alert_pkg::*;
#(
  parameter int unsigned NAlerts = NAlertsDef,
  parameter int unsigned NEsc    = NEscDef,
  parameter int unsigned CntDw   = CntDwDef
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [NAlerts-1:0] alert_ping_en_i,
  input  logic [CntDw-1:0]   wait_cyc_i,
  input  logic [CntDw-1:0]   timeout_cyc_i,
  output logic [NAlerts-1:0] alert_ping_req_o,
  output logic [NEsc-1:0]    esc_ping_req_o,
  input  logic [NAlerts-1:0] alert_ping_ok_i,
  input  logic [NEsc-1:0]    esc_ping_ok_i,
  output logic               alert_ping_fail_o,
  output logic               esc_ping_fail_o,
  output logic               busy_o
);

  localparam int unsigned NSlots = NAlerts + NEsc;
  localparam int unsigned PtrW   = $clog2(NSlots);
  localparam logic [PtrW-1:0] LastSlot = PtrW'(NSlots - 1);

  ping_state_e      state_q, state_d;
  logic [CntDw-1:0] cnt_q, cnt_d, lim_q, lim_d;
  logic [PtrW-1:0]  ptr_q, ptr_d, ptr_inc;
  logic             alert_fail_d, esc_fail_d;
  logic             cnt_done, skip_slot, ok_hit, slot_is_alert;

  logic [NAlerts-1:0] alert_oh_cur, alert_oh_nxt;
  logic [NEsc-1:0]    esc_oh_cur, esc_oh_nxt;

  // Zero-length periods behave as one cycle so the FSM always makes progress.
  function automatic logic [CntDw-1:0] at_least_one(input logic [CntDw-1:0] v);
    return (v == '0) ? CntDw'(1) : v;
  endfunction

  alert_handler_ping_slot_dec #(
    .NAlerts(NAlerts), .NEsc(NEsc), .PtrW(PtrW)
  ) u_dec_cur (
    .ptr      (ptr_q),
    .alert_oh (alert_oh_cur),
    .esc_oh   (esc_oh_cur)
  );

  alert_handler_ping_slot_dec #(
    .NAlerts(NAlerts), .NEsc(NEsc), .PtrW(PtrW)
  ) u_dec_nxt (
    .ptr      (ptr_d),
    .alert_oh (alert_oh_nxt),
    .esc_oh   (esc_oh_nxt)
  );

  assign ptr_inc       = (ptr_q == LastSlot) ? '0 : ptr_q + PtrW'(1);
  assign cnt_done      = (cnt_q >= lim_q - CntDw'(1));
  assign slot_is_alert = |alert_oh_cur;
  assign skip_slot     = |(alert_oh_cur & ~alert_ping_en_i);
  // Only the ok line of the slot currently being pinged can end a ping.
  assign ok_hit        = |(alert_ping_req_o & alert_ping_ok_i) |
                         |(esc_ping_req_o & esc_ping_ok_i);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lim_d        = lim_q;
    ptr_d        = ptr_q;
    alert_fail_d = 1'b0;
    esc_fail_d   = 1'b0;
    if (!en_i) begin
      state_d = PsIdle;
      cnt_d   = '0;
      lim_d   = '0;
      ptr_d   = '0;
    end else begin
      unique case (state_q)
        PsIdle: begin
          state_d = PsWait;
          cnt_d   = '0;
          lim_d   = at_least_one(wait_cyc_i);
          ptr_d   = '0;
        end
        PsWait: begin
          if (cnt_done) begin
            cnt_d = '0;
            if (skip_slot) begin
              ptr_d = ptr_inc;
              lim_d = at_least_one(wait_cyc_i);
            end else begin
              state_d = PsPing;
              lim_d   = at_least_one(timeout_cyc_i);
            end
          end else begin
            cnt_d = cnt_q + CntDw'(1);
          end
        end
        PsPing: begin
          // A response arriving on the last allowed cycle still counts as success.
          if (ok_hit || cnt_done) begin
            if (!ok_hit) begin
              alert_fail_d = slot_is_alert;
              esc_fail_d   = !slot_is_alert;
            end
            state_d = PsWait;
            cnt_d   = '0;
            lim_d   = at_least_one(wait_cyc_i);
            ptr_d   = ptr_inc;
          end else begin
            cnt_d = cnt_q + CntDw'(1);
          end
        end
        default: begin
          state_d = PsIdle;
          cnt_d   = '0;
          lim_d   = '0;
          ptr_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q           <= PsIdle;
      cnt_q             <= '0;
      lim_q             <= '0;
      ptr_q             <= '0;
      alert_ping_req_o  <= '0;
      esc_ping_req_o    <= '0;
      alert_ping_fail_o <= 1'b0;
      esc_ping_fail_o   <= 1'b0;
      busy_o            <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      lim_q             <= lim_d;
      ptr_q             <= ptr_d;
      alert_ping_req_o  <= (state_d == PsPing) ? alert_oh_nxt : '0;
      esc_ping_req_o    <= (state_d == PsPing) ? esc_oh_nxt : '0;
      alert_ping_fail_o <= alert_fail_d;
      esc_ping_fail_o   <= esc_fail_d;
      busy_o            <= (state_d != PsIdle);
    end
  end

endmodule
